// File: rtl/mini_cpu_pkg.sv
// Shared opcodes, FSM encoding and immediate helper for the mini CPU controller.
package mini_cpu_pkg;

  localparam int DW_DEF = 16;
  localparam int AW_DEF = 4;

  localparam logic [2:0] OP_LOAD    = 3'b000;
  localparam logic [2:0] OP_ADD     = 3'b001;
  localparam logic [2:0] OP_ADDI    = 3'b010;
  localparam logic [2:0] OP_SUB     = 3'b011;
  localparam logic [2:0] OP_SUBI    = 3'b100;
  localparam logic [2:0] OP_MUL     = 3'b101;
  localparam logic [2:0] OP_CLEAR   = 3'b110;
  localparam logic [2:0] OP_DISPLAY = 3'b111;

  typedef enum logic [2:0] {
    S_OFF,
    S_IDLE,
    S_READ,
    S_EXEC,
    S_WB,
    S_SHOW,
    S_CLR
  } state_t;

  // Sign-magnitude 6-bit immediate to two's complement; -0 collapses to 0.
  function automatic logic [DW_DEF-1:0] sext_imm(input logic neg, input logic [5:0] mag);
    logic [DW_DEF-1:0] m;
    m = {{(DW_DEF-6){1'b0}}, mag};
    if (neg) m = ~m + {{(DW_DEF-1){1'b0}}, 1'b1};
    return m;
  endfunction

endpackage

// File: rtl/mini_cpu_control_button_edge_sync.sv
// Two-flop synchronizer with a rising-edge one-shot for board buttons/switches.
module button_edge_sync (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic pulse
);

  logic [1:0] sync_q;
  logic       prev_q;

  // Reset loads the "pressed" level so a button held through reset must be
  // released and pressed again before it produces a pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= 2'b11;
      prev_q <= 1'b1;
    end else begin
      sync_q <= {sync_q[0], din};
      prev_q <= sync_q[1];
    end
  end

  assign pulse = sync_q[1] & ~prev_q;

endmodule

// File: rtl/mini_cpu_control.sv
// Instruction sequencer: latches switch fields on a button press and walks
// the register RAM / ALU through read, execute, write-back and display.
//
// state | meaning
// OFF   | power switch low, nothing runs
// IDLE  | waiting for a button press
// READ  | RAM read addresses driven
// EXEC  | ALU operands driven
// WB    | single RAM write of the result
// SHOW  | LCD refresh strobe
// CLR   | sweep writing 0 to every register
module mini_cpu_control
  import mini_cpu_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int AW = AW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ligar,
  input  logic          enviar,
  input  logic [2:0]    opcode,
  input  logic [AW-1:0] src1,
  input  logic [AW-1:0] src2,
  input  logic [AW-1:0] dest,
  input  logic          sinalImm,
  input  logic [5:0]    imm,
  output logic [AW-1:0] ram_addr1,
  output logic [AW-1:0] ram_addr2,
  input  logic [DW-1:0] ram_q1,
  input  logic [DW-1:0] ram_q2,
  output logic [AW-1:0] ram_waddr,
  output logic [DW-1:0] ram_wdata,
  output logic          ram_we,
  output logic [2:0]    alu_op,
  output logic [DW-1:0] alu_a,
  output logic [DW-1:0] alu_b,
  input  logic [DW-1:0] alu_y,
  output logic          busy,
  output logic [DW-1:0] lcd_value,
  output logic          lcd_show,
  output logic          lcd_update
);

  state_t        state, state_nxt;
  logic          go;
  logic          accept;
  logic [2:0]    op_r;
  logic [AW-1:0] src1_r, src2_r, dest_r;
  logic [DW-1:0] immx_r;
  logic [DW-1:0] wb_val_r;
  logic [DW-1:0] lcd_reg;
  logic          lcd_show_r;
  logic [AW-1:0] clr_cnt;
  logic [DW-1:0] show_val;

  button_edge_sync u_enviar_sync (
    .clk   (clk),
    .rst   (rst),
    .din   (enviar),
    .pulse (go)
  );

  assign accept = (state == S_IDLE) && go && ligar;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_OFF;
      op_r       <= OP_LOAD;
      src1_r     <= '0;
      src2_r     <= '0;
      dest_r     <= '0;
      immx_r     <= '0;
      wb_val_r   <= '0;
      lcd_reg    <= '0;
      lcd_show_r <= 1'b0;
      clr_cnt    <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        op_r    <= opcode;
        src1_r  <= src1;
        src2_r  <= src2;
        dest_r  <= dest;
        immx_r  <= DW'(sext_imm(sinalImm, imm));
        clr_cnt <= '0;
      end else if (state == S_CLR) begin
        clr_cnt <= clr_cnt + AW'(1);
      end
      if (state == S_WB) wb_val_r <= ram_wdata;
      // Display registers only move on a completed SHOW, so a power-off abort holds them.
      if (state == S_SHOW && ligar) begin
        lcd_reg    <= show_val;
        lcd_show_r <= (op_r != OP_CLEAR);
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_OFF:  if (ligar) state_nxt = S_IDLE;
      S_IDLE: begin
        if (go) begin
          if (opcode == OP_LOAD)       state_nxt = S_WB;
          else if (opcode == OP_CLEAR) state_nxt = S_CLR;
          else                         state_nxt = S_READ;
        end
      end
      S_READ: state_nxt = (op_r == OP_DISPLAY) ? S_SHOW : S_EXEC;
      S_EXEC: state_nxt = S_WB;
      S_WB:   state_nxt = S_SHOW;
      S_SHOW: state_nxt = S_IDLE;
      S_CLR:  if (clr_cnt == '1) state_nxt = S_SHOW;
      default: state_nxt = S_OFF;
    endcase
    if (!ligar) state_nxt = S_OFF;
  end

  always_comb begin
    ram_addr1  = '0;
    ram_addr2  = '0;
    ram_waddr  = '0;
    ram_wdata  = '0;
    ram_we     = 1'b0;
    alu_op     = 3'b000;
    alu_a      = '0;
    alu_b      = '0;
    lcd_update = 1'b0;
    show_val   = wb_val_r;
    if (op_r == OP_DISPLAY)    show_val = ram_q1;
    else if (op_r == OP_CLEAR) show_val = '0;

    case (state)
      S_READ: begin
        ram_addr1 = src1_r;
        ram_addr2 = src2_r;
      end
      S_EXEC: begin
        alu_a = ram_q1;
        case (op_r)
          OP_ADDI: begin alu_op = OP_ADD; alu_b = immx_r; end
          OP_SUBI: begin alu_op = OP_SUB; alu_b = immx_r; end
          default: begin alu_op = op_r;   alu_b = ram_q2; end
        endcase
      end
      S_WB: begin
        ram_we    = 1'b1;
        ram_waddr = dest_r;
        ram_wdata = (op_r == OP_LOAD) ? immx_r : alu_y;
      end
      S_CLR: begin
        ram_we    = 1'b1;
        ram_waddr = clr_cnt;
      end
      S_SHOW: lcd_update = 1'b1;
      default: ;
    endcase
    ram_we = ram_we && ligar && !rst;
  end

  assign busy      = (state != S_IDLE) && (state != S_OFF);
  assign lcd_value = (state == S_SHOW) ? show_val : lcd_reg;
  assign lcd_show  = (state == S_SHOW) ? (op_r != OP_CLEAR) : lcd_show_r;

endmodule
